serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 14 +
 rtl/adder_slice_4.sv | 25 ++
 rtl/serial_add_ctrl.sv | 137 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial nibble adder.
// Controller states and the width of the shared adder slice live here so the
// controller and the slice agree on them.
package serial_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_slice_4.sv
// Purely combinational 4-bit ripple-carry adder slice.
// The serial controller reuses this one slice for every nibble of the operands.
module adder_slice_4
    import serial_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                carry_in,
    output logic [NIBBLE_W-1:0] sum,
    output logic                carry_out
);

    // Ripple the carry from bit 0 upward, one full adder per bit.
    always_comb begin
        logic c;
        sum = '0;
        c   = carry_in;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry_out = c;
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Serial adder: {carry_out, sum} = a + b + carry_in, one nibble per cycle,
// through a single shared 4-bit slice, with valid/ready handshakes on both sides.
// Optional build macro SERIAL_ADD_CTRL_SUB_EN adds an 'op' input; op = 1 selects
// a - b (b inverted per nibble, initial carry forced to 1, carry_out = no borrow).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SERIAL_ADD_CTRL_SUB_EN
    input  logic             op,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [WIDTH-1:0]    sum_reg;
    logic                carry_reg;
    logic                in_ready_reg;
    logic                out_valid_reg;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] b_eff;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_carry;
    logic                start_carry;

`ifdef SERIAL_ADD_CTRL_SUB_EN
    logic op_reg;
    assign b_eff       = op_reg ? ~b_nib : b_nib;
    assign start_carry = op ? 1'b1 : carry_in;
`else
    assign b_eff       = b_nib;
    assign start_carry = carry_in;
`endif

    // Pick nibble 'cnt' of the registered operands for the shared slice.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CNT_W'(i)) begin
                a_nib = a_reg[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_reg[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    adder_slice_4 u_slice (
        .a         (a_nib),
        .b         (b_eff),
        .carry_in  (carry_reg),
        .sum       (slice_sum),
        .carry_out (slice_carry)
    );

    // Controller FSM: accept in IDLE, one nibble per RUN cycle, hold result in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
            op_reg        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        carry_reg    <= start_carry;
`ifdef SERIAL_ADD_CTRL_SUB_EN
                        op_reg       <= op;
`endif
                        cnt          <= '0;
                        in_ready_reg <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (cnt == CNT_W'(i)) begin
                            sum_reg[i*NIBBLE_W +: NIBBLE_W] <= slice_sum;
                        end
                    end
                    carry_reg <= slice_carry;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST_NIB) begin
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign carry_out = carry_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH = 16 main instance plus a
// WIDTH = 4 instance). Build with SERIAL_ADD_CTRL_SUB_EN to exercise subtract.
module tb_serial_add_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         carry_in = 1'b0;
    logic         out_ready = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         carry_out;

    logic         in_valid4 = 1'b0;
    logic         carry_in4 = 1'b0;
    logic         out_ready4 = 1'b0;
    logic         op4 = 1'b0;
    logic [3:0]   a4 = '0;
    logic [3:0]   b4 = '0;
    logic         in_ready4;
    logic         out_valid4;
    logic [3:0]   sum4;
    logic         carry_out4;

    int tests = 0;
    int fails = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SERIAL_ADD_CTRL_SUB_EN
        .op        (op),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
`ifdef SERIAL_ADD_CTRL_SUB_EN
        .op        (op4),
`endif
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .carry_in  (carry_in4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .carry_out (carry_out4)
    );

    always #5 clk = ~clk;

    // Single comparison helper; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Arithmetic reference: full-width add, or a - b as a + ~b + 1.
    function automatic logic [W:0] expectResult(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic c, input logic sub);
        if (sub)
            return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        return {1'b0, x} + {1'b0, y} + (W+1)'(c);
    endfunction

    // Transaction-level model: busy after an accept, result due NIB edges later,
    // released by out_ready once due.
    bit           m_live  = 1'b0;
    bit           m_busy  = 1'b0;
    bit           m_clean = 1'b0;
    int           m_age   = 0;
    logic [W-1:0] m_sum   = '0;
    logic         m_cout  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_live  = 1'b1;
            m_busy  = 1'b0;
            m_age   = 0;
            m_clean = 1'b1;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy  = 1'b1;
                m_age   = 0;
                m_clean = 1'b0;
                {m_cout, m_sum} = expectResult(a, b, carry_in, op);
            end
        end else if (m_age < NIB) begin
            m_age++;
        end else if (out_ready) begin
            m_busy = 1'b0;
        end
    end

    // Compare the main instance against the model on every falling edge.
    always @(negedge clk) begin
        if (m_live) begin
            checkOutput("in_ready", in_ready, !m_busy);
            checkOutput("out_valid", out_valid, m_busy && (m_age == NIB));
            if (m_busy && (m_age == NIB)) begin
                checkOutput("sum", sum, m_sum);
                checkOutput("carry_out", carry_out, m_cout);
            end
            if (m_clean && !m_busy) begin
                checkOutput("sum_after_reset", sum, 0);
                checkOutput("carry_after_reset", carry_out, 0);
            end
        end
    end

    // Drive one transfer into the main instance, measure latency, capture the
    // result, then hold off out_ready for 'hold' cycles (optionally with a
    // competing in_valid pending) before consuming it.
    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                 input logic sub, input int hold, input bit pend,
                                 output int lat, output logic [W-1:0] rs, output logic rc);
        bit   ok;
        logic r;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        carry_in = c;
        op       = sub;
        ok       = 1'b0;
        lat      = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            if (r === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        #1 in_valid = 1'b0;
        checkOutput("accept_timeout", ok, 1);
        ok = 1'b0;
        for (int t = 1; t <= 50; t++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                lat = t;
                ok  = 1'b1;
                break;
            end
        end
        checkOutput("result_timeout", ok, 1);
        rs = sum;
        rc = carry_out;
        if (pend) begin
            in_valid = 1'b1;
            a        = ~x;
            b        = ~y;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            if (pend) begin
                checkOutput("bp_sum_stable", sum, rs);
                checkOutput("bp_out_valid", out_valid, 1);
                checkOutput("bp_in_ready", in_ready, 0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    // Single transfer into the WIDTH = 4 instance, checked against plain arithmetic.
    task automatic run4(input logic [3:0] x, input logic [3:0] y, input logic c, input string name);
        logic [4:0] e;
        bit         ok;
        int         lat;
        e = {1'b0, x} + {1'b0, y} + 5'(c);
        in_valid4 = 1'b1;
        a4 = x;
        b4 = y;
        carry_in4 = c;
        checkOutput({name, "_in_ready"}, in_ready4, 1);
        @(posedge clk);
        #1 in_valid4 = 1'b0;
        ok  = 1'b0;
        lat = 0;
        for (int t = 1; t <= 20; t++) begin
            @(posedge clk);
            #1;
            if (out_valid4 === 1'b1) begin
                lat = t;
                ok  = 1'b1;
                break;
            end
        end
        checkOutput({name, "_timeout"}, ok, 1);
        checkOutput({name, "_latency"}, lat, 1);
        checkOutput({name, "_sum"}, sum4, e[3:0]);
        checkOutput({name, "_carry"}, carry_out4, e[4]);
        out_ready4 = 1'b1;
        @(posedge clk);
        #1 out_ready4 = 1'b0;
    endtask

    initial begin
        int           lat;
        logic [W-1:0] rs;
        logic         rc;
        bit           ok;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_sum", sum, 0);
        checkOutput("reset_carry", carry_out, 0);
        checkOutput("reset4_in_ready", in_ready4, 1);
        checkOutput("reset4_out_valid", out_valid4, 0);

        // Hand-computed expectations.
        applyStimulus(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, 1'b0, lat, rs, rc);
        checkOutput("d1_sum", rs, 16'h2233);
        checkOutput("d1_carry", rc, 0);
        checkOutput("d1_latency", lat, 4);

        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 1'b0, lat, rs, rc);
        checkOutput("d2_sum", rs, 16'h0000);
        checkOutput("d2_carry", rc, 1);
        checkOutput("d2_latency", lat, 4);

        applyStimulus(16'h8000, 16'h7FFF, 1'b1, 1'b0, 0, 1'b0, lat, rs, rc);
        checkOutput("d3_sum", rs, 16'h0000);
        checkOutput("d3_carry", rc, 1);

        // Backpressure for five cycles with a competing request pending.
        applyStimulus(16'hA5A5, 16'h1111, 1'b1, 1'b0, 5, 1'b1, lat, rs, rc);
        checkOutput("bp_sum", rs, 16'hB6B7);
        checkOutput("bp_carry", rc, 0);

        // Reset asserted during the second RUN cycle.
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h4321;
        carry_in = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("rst_run_in_ready", in_ready, 1);
        checkOutput("rst_run_out_valid", out_valid, 0);
        checkOutput("rst_run_sum", sum, 0);
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0, lat, rs, rc);
        checkOutput("after_rst_sum", rs, 16'h0002);
        checkOutput("after_rst_carry", rc, 0);

`ifdef SERIAL_ADD_CTRL_SUB_EN
        applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0, lat, rs, rc);
        checkOutput("sub1_sum", rs, 16'hFFFE);
        checkOutput("sub1_carry", rc, 0);
        applyStimulus(16'h0007, 16'h0005, 1'b1, 1'b1, 0, 1'b0, lat, rs, rc);
        checkOutput("sub2_sum", rs, 16'h0002);
        checkOutput("sub2_carry", rc, 1);
`endif

        // Randomized traffic, checked by the model on every cycle.
        for (int n = 0; n < 40; n++) begin
            logic sub;
            sub = 1'b0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
            sub = 1'($urandom_range(0, 1));
`endif
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), sub,
                          int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), lat, rs, rc);
            checkOutput("rand_latency", lat, NIB);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        // WIDTH = 4 instance: one RUN cycle per transfer.
        run4(4'hF, 4'h1, 1'b1, "w4_dir");
        for (int n = 0; n < 8; n++) begin
            run4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), "w4_rand");
        end

        ok = 1'b1;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
